data_memory_pipelined: RTL and testbench

//   Parametrised single-clock data memory with independent read and write ports,
//   per-byte write strobes, configurable registered read latency and an error flag
//   for misaligned or out-of-range accesses.
//   It serves as the load/store memory of the RV32I core, between the core's

---
 rtl/data_memory_pipelined_if.sv | 30 +++
 rtl/data_memory_pipelined.sv | 113 +++++++++++
 tb/tb_data_memory_pipelined.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pipelined_if.sv
// Bus bundle for the pipelined data memory: one read port and one byte-strobed write port.
// Both ports take a request at every rising edge where the enable is high. There is no ready
// signal and no backpressure. read_valid is high for one cycle and marks read_value and read_error.
interface data_memory_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                      read_enable;
   logic [ADDR_WIDTH-1:0]     read_address;
   logic [DATA_WIDTH-1:0]     read_value;
   logic                      read_valid;
   logic                      read_error;
   logic                      write_enable;
   logic [ADDR_WIDTH-1:0]     write_address;
   logic [DATA_WIDTH-1:0]     write_value;
   logic [DATA_WIDTH/8-1:0]   write_strobe;
   logic                      write_error;

   modport master (
      output read_enable, read_address,
      output write_enable, write_address, write_value, write_strobe,
      input  read_value, read_valid, read_error, write_error
   );

   modport slave (
      input  read_enable, read_address,
      input  write_enable, write_address, write_value, write_strobe,
      output read_value, read_valid, read_error, write_error
   );
endinterface

// File: rtl/data_memory_pipelined.sv
// Load/store data memory for the RV32I core. It has byte-strobed writes, a read pipeline of
// READ_LATENCY stages with write-first forwarding, and error flags for illegal addresses.
module data_memory_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   data_memory_pipelined_if.slave mem_bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..4");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two, at least 2");
   end
   if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8, at least 8");
   end
   if (ADDR_WIDTH < OFF + IDX_W) begin : g_bad_addr
      $error("ADDR_WIDTH too narrow to address DEPTH words");
   end

   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] r_pipe_vld;
   logic [READ_LATENCY-1:0] r_pipe_err;
   logic                    r_wr_err;

   logic                    w_rd_legal;
   logic                    w_wr_legal;
   logic                    w_wr_do;
   logic                    w_wr_hit;
   logic [IDX_W-1:0]        w_rd_idx;
   logic [IDX_W-1:0]        w_wr_idx;
   logic [DATA_WIDTH-1:0]   w_wr_merged;
   logic [DATA_WIDTH-1:0]   w_rd_data;

   // A legal access is word-aligned and has every bit above the word index at zero.
   assign w_rd_legal = ((mem_bus.read_address & OFF_MASK) == '0) &&
                       ((mem_bus.read_address >> (OFF + IDX_W)) == '0);
   assign w_wr_legal = ((mem_bus.write_address & OFF_MASK) == '0) &&
                       ((mem_bus.write_address >> (OFF + IDX_W)) == '0);

   assign w_rd_idx = IDX_W'(mem_bus.read_address >> OFF);
   assign w_wr_idx = IDX_W'(mem_bus.write_address >> OFF);

   assign w_wr_do  = mem_bus.write_enable && w_wr_legal;
   assign w_wr_hit = w_wr_do && (w_wr_idx == w_rd_idx);

   // This is the word as it will look after this edge's write. A read of the same word returns it.
   always_comb begin
      w_wr_merged = r_mem[w_wr_idx];
      for (int i = 0; i < BYTES; i++) begin
         if (mem_bus.write_strobe[i]) begin
            w_wr_merged[8*i +: 8] = mem_bus.write_value[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_rd_data = '0;
      if (w_rd_legal) begin
         w_rd_data = w_wr_hit ? w_wr_merged : r_mem[w_rd_idx];
      end
   end

   // The array has no reset. Its contents are undefined until written.
   always_ff @(posedge clock) begin
      if (w_wr_do) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mem_bus.write_strobe[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= mem_bus.write_value[8*i +: 8];
            end
         end
      end
   end

   // The data stages carry zero whenever their valid bit is low. The output then needs no gating.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_vld <= '0;
         r_pipe_err <= '0;
         r_wr_err   <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_vld[0]  <= mem_bus.read_enable;
         r_pipe_err[0]  <= mem_bus.read_enable && !w_rd_legal;
         r_pipe_data[0] <= mem_bus.read_enable ? w_rd_data : '0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_err[i]  <= r_pipe_err[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
         r_wr_err <= mem_bus.write_enable && !w_wr_legal;
      end
   end

   assign mem_bus.read_valid  = r_pipe_vld[READ_LATENCY-1];
   assign mem_bus.read_error  = r_pipe_err[READ_LATENCY-1];
   assign mem_bus.read_value  = r_pipe_data[READ_LATENCY-1];
   assign mem_bus.write_error = r_wr_err;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: two 32-bit instances (latency 1 and 3) against a reference model,
// and a 64-bit, 16-word, latency-2 instance exercised with directed boundary and reset sequences.
module tb_data_memory_pipelined;
   logic clk = 1'b0;
   logic rst_n;
   logic rst_c_n;

   always #5 clk = ~clk;

   data_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
   data_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();
   data_memory_pipelined_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) ifc ();

   assign ifb.read_enable   = ifa.read_enable;
   assign ifb.read_address  = ifa.read_address;
   assign ifb.write_enable  = ifa.write_enable;
   assign ifb.write_address = ifa.write_address;
   assign ifb.write_value   = ifa.write_value;
   assign ifb.write_strobe  = ifa.write_strobe;

   data_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1))
      u_dut_a (.clock(clk), .reset_n(rst_n), .mem_bus(ifa.slave));
   data_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .READ_LATENCY(3))
      u_dut_b (.clock(clk), .reset_n(rst_n), .mem_bus(ifb.slave));
   data_memory_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(2))
      u_dut_c (.clock(clk), .reset_n(rst_c_n), .mem_bus(ifc.slave));

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // The model memory is indexed by word. Each queue entry packs {due_edge[15:0], error, data[31:0]}.
   logic [31:0] mdl [int];
   logic [48:0] exp_qa [$];
   logic [48:0] exp_qb [$];
   logic        exp_werr;
   logic [31:0] last_a_val;
   logic        last_a_err;

   logic        s_re, s_we;
   logic [31:0] s_ra, s_wa, s_wv;
   logic [3:0]  s_ws;

   localparam logic [63:0] V0 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] V1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] V2 = 64'hDEAD_BEEF_CAFE_F00D;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic legal32(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'h0000_1000);
   endfunction

   function automatic logic [31:0] rnd_addr();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_1000 + 4 * $urandom_range(0, 255);
         1:       return 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
         2:       return 32'h0000_0FFC;
         3:       return $urandom() | 32'h8000_0000;
         default: return 4 * $urandom_range(0, 15);
      endcase
   endfunction

   task automatic score_one(input int which, input logic vld, input logic err, input logic [31:0] val);
      logic [48:0] e;
      logic        due_now;
      string       p;
      p = (which == 0) ? "a" : "b";
      if (which == 0) due_now = (exp_qa.size() > 0) && (exp_qa[0][48:33] == edge_n[15:0]);
      else            due_now = (exp_qb.size() > 0) && (exp_qb[0][48:33] == edge_n[15:0]);
      if (due_now) begin
         e = (which == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
         check_val({p, "_valid"}, vld, 1'b1);
         check_val({p, "_err"}, err, e[32]);
         check_val({p, "_data"}, val, e[31:0]);
      end else begin
         check_val({p, "_idle_valid"}, vld, 1'b0);
         check_val({p, "_idle_value"}, val, 32'h0);
      end
   endtask

   // This drives one request cycle into both 32-bit instances. The model applies the write before
   // the read, so a same-word read sees the written bytes (write-first).
   task automatic step_ab(input logic re, input logic [31:0] ra, input logic we,
                          input logic [31:0] wa, input logic [31:0] wv, input logic [3:0] ws);
      logic [31:0] rd;
      logic        rerr;
      ifa.read_enable   = re;
      ifa.read_address  = ra;
      ifa.write_enable  = we;
      ifa.write_address = wa;
      ifa.write_value   = wv;
      ifa.write_strobe  = ws;
      @(posedge clk);
      edge_n++;
      if (we && legal32(wa)) begin
         for (int i = 0; i < 4; i++) begin
            if (ws[i]) mdl[int'(wa >> 2)][8*i +: 8] = wv[8*i +: 8];
         end
      end
      exp_werr = we && !legal32(wa);
      if (re) begin
         rerr = !legal32(ra);
         rd   = rerr ? 32'h0 : mdl[int'(ra >> 2)];
         exp_qa.push_back({16'(edge_n), rerr, rd});
         exp_qb.push_back({16'(edge_n + 2), rerr, rd});
      end
      @(negedge clk);
      score_one(0, ifa.read_valid, ifa.read_error, ifa.read_value);
      score_one(1, ifb.read_valid, ifb.read_error, ifb.read_value);
      check_val("a_werr", ifa.write_error, exp_werr);
      check_val("b_werr", ifb.write_error, exp_werr);
      if (ifa.read_valid) begin
         last_a_val = ifa.read_value;
         last_a_err = ifa.read_error;
      end
   endtask

   task automatic step_c(input logic re, input logic [31:0] ra, input logic we,
                         input logic [31:0] wa, input logic [63:0] wv, input logic [7:0] ws);
      ifc.read_enable   = re;
      ifc.read_address  = ra;
      ifc.write_enable  = we;
      ifc.write_address = wa;
      ifc.write_value   = wv;
      ifc.write_strobe  = ws;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_c(input string tag, input logic vld, input logic err,
                          input logic [63:0] val, input logic werr);
      check_val({tag, "_valid"}, ifc.read_valid, vld);
      check_val({tag, "_err"}, ifc.read_error, err);
      check_val({tag, "_value"}, ifc.read_value, val);
      check_val({tag, "_werr"}, ifc.write_error, werr);
   endtask

   initial begin
      ifa.read_enable = 1'b0; ifa.read_address = '0; ifa.write_enable = 1'b0;
      ifa.write_address = '0; ifa.write_value = '0; ifa.write_strobe = '0;
      ifc.read_enable = 1'b0; ifc.read_address = '0; ifc.write_enable = 1'b0;
      ifc.write_address = '0; ifc.write_value = '0; ifc.write_strobe = '0;
      last_a_val = '0;
      last_a_err = 1'b0;
      exp_werr   = 1'b0;
      rst_n   = 1'b0;
      rst_c_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_a_valid", ifa.read_valid, 1'b0);
      check_val("rst_a_value", ifa.read_value, 32'h0);
      check_val("rst_a_err", ifa.read_error, 1'b0);
      check_val("rst_a_werr", ifa.write_error, 1'b0);
      check_val("rst_b_valid", ifb.read_valid, 1'b0);
      check_val("rst_b_werr", ifb.write_error, 1'b0);
      check_c("rst_c", 1'b0, 1'b0, 64'h0, 1'b0);
      rst_n   = 1'b1;
      rst_c_n = 1'b1;

      // 64-bit, 16-word instance: the last word is 0x78, and 0x80 is out of range and would alias word 0.
      step_c(1'b0, 32'h0,  1'b1, 32'h78, V1, 8'hFF);
      check_c("c_wr_last", 1'b0, 1'b0, 64'h0, 1'b0);
      step_c(1'b0, 32'h0,  1'b1, 32'h0,  V0, 8'hFF);
      step_c(1'b1, 32'h78, 1'b1, 32'h80, V2, 8'hFF);
      check_c("c_wr_oor", 1'b0, 1'b0, 64'h0, 1'b1);
      step_c(1'b1, 32'h0,  1'b1, 32'h4,  V2, 8'hFF);
      check_c("c_rd_last", 1'b1, 1'b0, V1, 1'b1);
      step_c(1'b1, 32'h80, 1'b0, 32'h0,  64'h0, 8'h00);
      check_c("c_rd_word0", 1'b1, 1'b0, V0, 1'b0);
      step_c(1'b0, 32'h0,  1'b0, 32'h0,  64'h0, 8'h00);
      check_c("c_rd_oor", 1'b1, 1'b1, 64'h0, 1'b0);
      step_c(1'b0, 32'h0,  1'b0, 32'h0,  64'h0, 8'h00);
      check_c("c_idle", 1'b0, 1'b0, 64'h0, 1'b0);

      // Reset arrives with reads in flight. The outputs must clear at once, and nothing may emerge afterwards.
      step_c(1'b1, 32'h78, 1'b0, 32'h0, 64'h0, 8'h00);
      step_c(1'b1, 32'h0,  1'b1, 32'h4, V2, 8'hFF);
      check_c("c_pre_rst", 1'b1, 1'b0, V1, 1'b1);
      ifc.read_enable  = 1'b0;
      ifc.write_enable = 1'b0;
      rst_c_n = 1'b0;
      #1;
      check_c("c_in_rst", 1'b0, 1'b0, 64'h0, 1'b0);
      repeat (2) @(negedge clk);
      rst_c_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step_c(1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 8'h00);
         check_c("c_post_rst", 1'b0, 1'b0, 64'h0, 1'b0);
      end
      step_c(1'b1, 32'h78, 1'b0, 32'h0, 64'h0, 8'h00);
      step_c(1'b0, 32'h0,  1'b0, 32'h0, 64'h0, 8'h00);
      check_c("c_kept_contents", 1'b1, 1'b0, V1, 1'b0);

      // 32-bit instances: initialise the words used below, and the last word.
      for (int w = 0; w < 16; w++) step_ab(1'b0, 32'h0, 1'b1, 32'(4 * w), $urandom(), 4'hF);
      step_ab(1'b0, 32'h0, 1'b1, 32'h0000_0FFC, 32'h5A5A_0FFC, 4'hF);

      step_ab(1'b0, 32'h0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
      step_ab(1'b0, 32'h0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
      step_ab(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
      check_val("strobe_merge", last_a_val, 32'hAA22_CC44);

      step_ab(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      step_ab(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 4'h0);
      step_ab(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) step_ab(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

      step_ab(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'hF);
      step_ab(1'b1, 32'h20, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
      check_val("rdw_merge", last_a_val, 32'h0000_BEEF);

      step_ab(1'b0, 32'h0, 1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF);
      check_val("werr_misaligned", ifa.write_error, 1'b1);
      step_ab(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 4'h0);
      check_val("rerr_oor_flag", last_a_err, 1'b1);
      check_val("rerr_oor_value", last_a_val, 32'h0);

      step_ab(1'b0, 32'h0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF);
      step_ab(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 32'h0, 4'h0);
      check_val("last_word", last_a_val, 32'h1234_5678);
      check_val("last_word_err", last_a_err, 1'b0);

      for (int n = 0; n < 400; n++) begin
         s_re = 1'($urandom_range(0, 1));
         s_we = 1'($urandom_range(0, 1));
         s_ra = rnd_addr();
         s_wa = ($urandom_range(0, 3) == 0) ? s_ra : rnd_addr();
         s_wv = $urandom();
         s_ws = 4'($urandom_range(0, 15));
         step_ab(s_re, s_ra, s_we, s_wa, s_wv, s_ws);
      end
      repeat (4) step_ab(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      check_val("qa_drained", 32'(exp_qa.size()), 32'h0);
      check_val("qb_drained", 32'(exp_qb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
